// File: rtl/spi_reg_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_slave_pkg
// Purpose  : Shared definitions for the SPI register slave: command opcodes,
//            FSM state encoding and the register-map decode helper.
// Revision : 1.0 - initial release
// ============================================================================
package spi_reg_slave_pkg;

    // ADXL362-style command opcodes (first byte of every transfer)
    localparam logic [7:0] C_CMD_WRITE = 8'h0A;
    localparam logic [7:0] C_CMD_READ  = 8'h0B;

    // Protocol FSM
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_DATA_WR = 3'd3,
        ST_DATA_RD = 3'd4,
        ST_IGNORE  = 3'd5
    } state_t;

    // True when the register address falls inside the implemented register map
    function automatic logic addr_mapped(input logic [7:0] addr, input int num_regs);
        return (32'(addr) < num_regs);
    endfunction

endpackage : spi_reg_slave_pkg
`default_nettype wire

// File: rtl/spi_reg_slave_sync.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_slave_sync
// Purpose  : Multi-flop synchronizer for one asynchronous input, plus
//            single-cycle rise/fall pulses derived from the synchronized level.
// Ports    : clk, reset     - system clock, synchronous active-high reset
//            i_async        - asynchronous input
//            o_level        - synchronized level
//            o_rise/o_fall  - one-clk pulses on synchronized edges
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_slave_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // The reset value is chosen per input so that leaving reset never looks
    // like an edge (ncs idles high, sck/mosi idle low).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule : spi_reg_slave_sync
`default_nettype wire

// File: rtl/spi_reg_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_reg_slave
// Purpose  : SPI mode-0 (CPOL=0, CPHA=0, MSB first) register slave. Decodes
//            write (0x0A) / read (0x0B) commands followed by an address and a
//            burst of data bytes, driving an external register-file port.
//            All SPI inputs are oversampled in the clk domain.
// Ports    : clk, reset            - system clock, synchronous active-high reset
//            sck_i, ncs_i, mosi_i  - asynchronous SPI inputs
//            miso_o, miso_oe       - SPI data out and its enable
//            reg_addr/re/rdata     - register read port (rdata valid 1 clk after re)
//            reg_we/wdata          - register write port
//            busy                  - chip select (synchronized) active
//            xfer_done             - pulse when ncs rises after >=1 full byte
// Revision : 1.0 - initial release
// ============================================================================
module spi_reg_slave
    import spi_reg_slave_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck_i,
    input  logic       ncs_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe,
    output logic [7:0] reg_addr,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       reg_we,
    output logic [7:0] reg_wdata,
    output logic       busy,
    output logic       xfer_done
);

    // ------------------------------------------------------------------
    // Input synchronizers (identical latency on all three inputs keeps
    // mosi aligned with the sck edge that samples it)
    // ------------------------------------------------------------------
    logic w_sck_rise, w_sck_fall, w_sck_level_unused;
    logic w_ncs_level, w_ncs_rise, w_ncs_fall;
    logic w_mosi_level, w_mosi_rise_unused, w_mosi_fall_unused;

    spi_reg_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
        .clk     (clk),
        .reset   (reset),
        .i_async (sck_i),
        .o_level (w_sck_level_unused),
        .o_rise  (w_sck_rise),
        .o_fall  (w_sck_fall)
    );

    spi_reg_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk     (clk),
        .reset   (reset),
        .i_async (ncs_i),
        .o_level (w_ncs_level),
        .o_rise  (w_ncs_rise),
        .o_fall  (w_ncs_fall)
    );

    spi_reg_slave_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk     (clk),
        .reset   (reset),
        .i_async (mosi_i),
        .o_level (w_mosi_level),
        .o_rise  (w_mosi_rise_unused),
        .o_fall  (w_mosi_fall_unused)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_rx;            // first 7 bits of the byte in flight
    logic [7:0] r_tx;
    logic [7:0] r_addr;
    logic       r_is_read;
    logic       r_byte_seen;     // at least one full byte in this transfer
    logic       r_load_pending;  // read issued last clk: capture rdata now
    logic       r_load_mapped;
    logic       r_miso;
    logic [7:0] r_reg_addr;
    logic       r_reg_re;
    logic       r_reg_we;
    logic [7:0] r_reg_wdata;
    logic       r_xfer_done;

    // Completed byte, valid in the clk where the 8th rise is detected
    logic [7:0] w_byte;
    logic       w_byte_done;

    assign w_byte      = {r_rx, w_mosi_level};
    assign w_byte_done = w_sck_rise && (r_bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_bit_cnt      <= 3'd0;
            r_rx           <= 7'd0;
            r_tx           <= 8'd0;
            r_addr         <= 8'd0;
            r_is_read      <= 1'b0;
            r_byte_seen    <= 1'b0;
            r_load_pending <= 1'b0;
            r_load_mapped  <= 1'b0;
            r_miso         <= 1'b0;
            r_reg_addr     <= 8'd0;
            r_reg_re       <= 1'b0;
            r_reg_we       <= 1'b0;
            r_reg_wdata    <= 8'd0;
            r_xfer_done    <= 1'b0;
        end else begin
            r_reg_re    <= 1'b0;
            r_reg_we    <= 1'b0;
            r_xfer_done <= 1'b0;

            // Read data arrives one clk after reg_re; the address advances
            // only after the capture so reg_addr stayed stable for the read.
            if (r_load_pending) begin
                r_tx           <= r_load_mapped ? reg_rdata : 8'h00;
                r_addr         <= r_addr + 8'd1;
                r_load_pending <= 1'b0;
            end

            if (w_ncs_level) begin
                // Deselected: abandon any partial byte; sck edges detected in
                // this clk are intentionally dropped.
                r_state        <= ST_IDLE;
                r_bit_cnt      <= 3'd0;
                r_rx           <= 7'd0;
                r_miso         <= 1'b0;
                r_load_pending <= 1'b0;
                r_byte_seen    <= 1'b0;
                if (w_ncs_rise && r_byte_seen) begin
                    r_xfer_done <= 1'b1;
                end
            end else if (r_state == ST_IDLE) begin
                if (w_ncs_fall) begin
                    r_state     <= ST_CMD;
                    r_bit_cnt   <= 3'd0;
                    r_rx        <= 7'd0;
                    r_tx        <= 8'd0;
                    r_byte_seen <= 1'b0;
                end
            end else begin
                if (w_sck_rise) begin
                    r_rx      <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end

                if (w_byte_done) begin
                    r_byte_seen <= 1'b1;
                    case (r_state)
                        ST_CMD: begin
                            if (w_byte == C_CMD_WRITE) begin
                                r_state   <= ST_ADDR;
                                r_is_read <= 1'b0;
                            end else if (w_byte == C_CMD_READ) begin
                                r_state   <= ST_ADDR;
                                r_is_read <= 1'b1;
                            end else begin
                                r_state   <= ST_IGNORE;
                            end
                        end
                        ST_ADDR: begin
                            r_addr <= w_byte;
                            if (r_is_read) begin
                                // Prefetch the first read byte right away so
                                // its MSB is ready for the next sck fall.
                                r_state        <= ST_DATA_RD;
                                r_load_pending <= 1'b1;
                                r_load_mapped  <= addr_mapped(w_byte, NUM_REGS);
                                if (addr_mapped(w_byte, NUM_REGS)) begin
                                    r_reg_re   <= 1'b1;
                                    r_reg_addr <= w_byte;
                                end
                            end else begin
                                r_state <= ST_DATA_WR;
                            end
                        end
                        ST_DATA_WR: begin
                            if (addr_mapped(r_addr, NUM_REGS)) begin
                                r_reg_we    <= 1'b1;
                                r_reg_addr  <= r_addr;
                                r_reg_wdata <= w_byte;
                            end
                            r_addr <= r_addr + 8'd1;
                        end
                        ST_DATA_RD: begin
                            r_load_pending <= 1'b1;
                            r_load_mapped  <= addr_mapped(r_addr, NUM_REGS);
                            if (addr_mapped(r_addr, NUM_REGS)) begin
                                r_reg_re   <= 1'b1;
                                r_reg_addr <= r_addr;
                            end
                        end
                        default: begin
                        end
                    endcase
                end

                // Only read data is ever shifted out; every other phase
                // keeps miso low.
                if (w_sck_fall) begin
                    if (r_state == ST_DATA_RD) begin
                        r_miso <= r_tx[7];
                        r_tx   <= {r_tx[6:0], 1'b0};
                    end else begin
                        r_miso <= 1'b0;
                    end
                end
            end
        end
    end

    assign miso_o    = r_miso;
    assign busy      = ~w_ncs_level;
    assign miso_oe   = ~w_ncs_level;
    assign reg_addr  = r_reg_addr;
    assign reg_re    = r_reg_re;
    assign reg_we    = r_reg_we;
    assign reg_wdata = r_reg_wdata;
    assign xfer_done = r_xfer_done;

endmodule : spi_reg_slave
`default_nettype wire

// File: tb/tb_spi_reg_slave.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_spi_reg_slave
// Purpose  : Self-checking bench for spi_reg_slave. A mode-0 SPI master
//            drives directed and randomized transfers; expected register
//            accesses, MISO bytes and xfer_done pulses come from a
//            transaction-level model of the command protocol.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_reg_slave;

    localparam int NUM_REGS = 64;

    logic       clk = 1'b0;
    logic       reset;
    logic       sck_i, ncs_i, mosi_i;
    logic       miso_o, miso_oe;
    logic [7:0] reg_addr;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       reg_we;
    logic [7:0] reg_wdata;
    logic       busy, xfer_done;

    always #5 clk = ~clk;

    spi_reg_slave #(.SYNC_STAGES(2), .NUM_REGS(NUM_REGS)) dut (
        .clk       (clk),
        .reset     (reset),
        .sck_i     (sck_i),
        .ncs_i     (ncs_i),
        .mosi_i    (mosi_i),
        .miso_o    (miso_o),
        .miso_oe   (miso_oe),
        .reg_addr  (reg_addr),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata),
        .busy      (busy),
        .xfer_done (xfer_done)
    );

    // Register file seen by the DUT, and the model's own copy
    logic [7:0]  mem     [256];
    logic [7:0]  exp_mem [256];

    // Observed activity
    logic [15:0] wr_q[$];
    logic [7:0]  rd_q[$];
    int          xd_cnt;
    int          miso_hi;

    // Expected activity
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    int          exp_xd;
    bit          exp_quiet;
    logic [7:0]  exp_miso [8];
    bit          miso_chk [8];

    logic [7:0]  tx_buf [8];
    logic [7:0]  rx_buf [8];
    int          half;
    int          n_vec = 0;
    int          n_err = 0;

    // Register-file environment and monitors, sampled on the inactive edge
    always @(negedge clk) begin
        if (!reset) begin
            if (reg_re) begin
                reg_rdata <= mem[reg_addr];
                rd_q.push_back(reg_addr);
            end
            if (reg_we) begin
                mem[reg_addr] <= reg_wdata;
                wr_q.push_back({reg_addr, reg_wdata});
            end
            if (xfer_done) xd_cnt++;
            if (busy && miso_o) miso_hi++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, ".miso_o"},    32'(miso_o),    32'd0);
        check({tag, ".miso_oe"},   32'(miso_oe),   32'd0);
        check({tag, ".reg_addr"},  32'(reg_addr),  32'd0);
        check({tag, ".reg_re"},    32'(reg_re),    32'd0);
        check({tag, ".reg_we"},    32'(reg_we),    32'd0);
        check({tag, ".reg_wdata"}, 32'(reg_wdata), 32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".xfer_done"}, 32'(xfer_done), 32'd0);
    endtask

    // Transaction-level expectation for tx_buf[0..] sent as nbits bits
    task automatic run_model(input int nbits);
        int         nfull;
        logic [7:0] a, ad;
        nfull = nbits / 8;
        exp_wr.delete();
        exp_rd.delete();
        exp_xd    = (nfull >= 1) ? 1 : 0;
        exp_quiet = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_miso[i] = 8'h00;
            miso_chk[i] = (i < nfull) && (i < 2);
        end
        if (nfull >= 1 && tx_buf[0] == 8'h0A) begin
            if (nfull >= 2) begin
                a = tx_buf[1];
                for (int i = 2; i < nfull; i++) begin
                    if (int'(a) < NUM_REGS) begin
                        exp_wr.push_back({a, tx_buf[i]});
                        exp_mem[a] = tx_buf[i];
                    end
                    a = a + 8'd1;
                end
            end
        end else if (nfull >= 1 && tx_buf[0] == 8'h0B) begin
            if (nfull >= 2) begin
                a = tx_buf[1];
                for (int j = 0; j < nfull - 1; j++) begin
                    ad = a + 8'(j);
                    if (int'(ad) < NUM_REGS) exp_rd.push_back(ad);
                end
                for (int i = 2; i < nfull; i++) begin
                    ad = a + 8'(i - 2);
                    miso_chk[i] = 1'b1;
                    exp_miso[i] = (int'(ad) < NUM_REGS) ? exp_mem[ad] : 8'h00;
                end
            end
        end else if (nfull >= 1) begin
            exp_quiet = 1'b1;
            for (int i = 0; i < nfull; i++) miso_chk[i] = 1'b1;
        end
    endtask

    // Mode-0 master; rst_at >= 0 asserts reset before that bit instead
    task automatic spi_xfer(input int nbits, input int rst_at);
        for (int i = 0; i < 8; i++) rx_buf[i] = 8'h00;
        @(posedge clk);
        #($urandom_range(1, 9));
        ncs_i  = 1'b0;
        mosi_i = tx_buf[0][7];
        #(half * 10);
        for (int k = 0; k < nbits; k++) begin
            if (k == rst_at) begin
                @(posedge clk);
                #1 reset = 1'b1;
                @(posedge clk);
                #1 check_outputs_zero("reset_mid");
                ncs_i  = 1'b1;
                sck_i  = 1'b0;
                mosi_i = 1'b0;
                repeat (4) @(posedge clk);
                #1 reset = 1'b0;
                repeat (4 * half + 8) @(posedge clk);
                return;
            end
            sck_i = 1'b1;
            rx_buf[k / 8][7 - (k % 8)] = miso_o;
            if (k == 0) begin
                check("busy_active", 32'(busy), 32'd1);
                check("miso_oe_active", 32'(miso_oe), 32'd1);
            end
            #(half * 10);
            sck_i = 1'b0;
            if (k + 1 < nbits) mosi_i = tx_buf[(k + 1) / 8][7 - ((k + 1) % 8)];
            #(half * 10);
        end
        ncs_i  = 1'b1;
        mosi_i = 1'b0;
        repeat (4 * half + 8) @(posedge clk);
        #1;
    endtask

    task automatic compare_all(input string name, input int nbits);
        int n;
        check({name, ".xfer_done"}, 32'(xd_cnt), 32'(exp_xd));
        check({name, ".n_writes"}, 32'(wr_q.size()), 32'(exp_wr.size()));
        n = (wr_q.size() < exp_wr.size()) ? wr_q.size() : exp_wr.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s.write%0d", name, i), 32'(wr_q[i]), 32'(exp_wr[i]));
        check({name, ".n_reads"}, 32'(rd_q.size()), 32'(exp_rd.size()));
        n = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s.read%0d", name, i), 32'(rd_q[i]), 32'(exp_rd[i]));
        for (int i = 0; i < nbits / 8 && i < 8; i++)
            if (miso_chk[i])
                check($sformatf("%s.miso%0d", name, i), 32'(rx_buf[i]), 32'(exp_miso[i]));
        if (exp_quiet) check({name, ".miso_quiet"}, 32'(miso_hi), 32'd0);
    endtask

    task automatic clear_mon();
        wr_q.delete();
        rd_q.delete();
        xd_cnt  = 0;
        miso_hi = 0;
    endtask

    task automatic do_xfer(input string name, input int nbits);
        clear_mon();
        run_model(nbits);
        spi_xfer(nbits, -1);
        compare_all(name, nbits);
    endtask

    task automatic load4(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
        tx_buf[0] = b0;
        tx_buf[1] = b1;
        tx_buf[2] = b2;
        tx_buf[3] = b3;
        for (int i = 4; i < 8; i++) tx_buf[i] = 8'($urandom);
    endtask

    initial begin
        logic [7:0] cmd;
        reset     = 1'b1;
        sck_i     = 1'b0;
        ncs_i     = 1'b1;
        mosi_i    = 1'b0;
        reg_rdata = 8'h00;
        half      = 4;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            exp_mem[i] = mem[i];
        end
        repeat (4) @(posedge clk);
        #1 check_outputs_zero("reset");
        reset = 1'b0;
        repeat (4) @(posedge clk);

        for (int s = 0; s < 2; s++) begin
            half = (s == 0) ? 4 : 16;

            // Write burst
            load4(8'h0A, 8'h1F, (s == 0) ? 8'h11 : 8'($urandom), (s == 0) ? 8'h22 : 8'($urandom));
            do_xfer($sformatf("wr_burst_s%0d", s), 32);

            // Read burst from preloaded registers
            mem[0] = 8'hAD; exp_mem[0] = 8'hAD;
            mem[1] = 8'hF2; exp_mem[1] = 8'hF2;
            load4(8'h0B, 8'h00, 8'($urandom), 8'($urandom));
            do_xfer($sformatf("rd_burst_s%0d", s), 32);

            // Unknown command
            load4(8'h07, 8'h1F, 8'h55, 8'h00);
            do_xfer($sformatf("bad_cmd_s%0d", s), 24);

            // Abort mid data byte, then read the untouched register back
            load4(8'h0A, 8'h10, 8'($urandom), 8'h00);
            do_xfer($sformatf("abort_s%0d", s), 21);
            load4(8'h0B, 8'h10, 8'($urandom), 8'h00);
            do_xfer($sformatf("abort_rd_s%0d", s), 24);

            // Unmapped addresses and address wrap
            load4(8'h0B, 8'h3F, 8'($urandom), 8'($urandom));
            do_xfer($sformatf("rd_unmapped_s%0d", s), 32);
            load4(8'h0A, 8'hFF, 8'h01, 8'h02);
            do_xfer($sformatf("wr_wrap_s%0d", s), 32);

            // Reset in the middle of a write data byte
            load4(8'h0A, 8'h05, 8'($urandom), 8'($urandom));
            clear_mon();
            spi_xfer(32, 20);
            check($sformatf("rst_mid_s%0d.n_writes", s), 32'(wr_q.size()), 32'd0);
            check($sformatf("rst_mid_s%0d.xfer_done", s), 32'(xd_cnt), 32'd0);
            check($sformatf("rst_mid_s%0d.idle_busy", s), 32'(busy), 32'd0);

            // Randomized transfers
            for (int r = 0; r < 3; r++) begin
                case ($urandom_range(0, 2))
                    0:       cmd = 8'h0A;
                    1:       cmd = 8'h0B;
                    default: cmd = 8'h40 | 8'($urandom_range(0, 63));
                endcase
                tx_buf[0] = cmd;
                tx_buf[1] = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'($urandom_range(60, 66));
                for (int i = 2; i < 8; i++) tx_buf[i] = 8'($urandom);
                do_xfer($sformatf("rand_s%0d_%0d", s, r), 8 * $urandom_range(1, 6));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_spi_reg_slave
`default_nettype wire
